// File: rtl/mult_share_arbiter_if.sv
// Requester/MAC side bundle of mult_share_arbiter.
interface mult_share_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0] Req_Set;
  logic [NREQ-1:0] Req_Clr;
  logic            Done;
  logic [NREQ-1:0] Grant;
  logic            Busy;
  logic [NREQ-1:0] Pending;
  logic            Timeout_Err;

  modport master (
    output Req_Set,
    output Req_Clr,
    output Done,
    input  Grant,
    input  Busy,
    input  Pending,
    input  Timeout_Err
  );

  modport slave (
    input  Req_Set,
    input  Req_Clr,
    input  Done,
    output Grant,
    output Busy,
    output Pending,
    output Timeout_Err
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one multi-cycle MAC between NREQ requesters, watchdog release.
// ARB_FIXED_PRIO_EN: lowest pending index wins instead of round-robin.
module mult_share_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int TW          = 8
) (
  input logic Clk,
  input logic Rst,
  mult_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] pend_q;
  logic [NREQ-1:0] pend_d;
  logic [NREQ-1:0] rel_mask;
  logic [TW-1:0]   wdog;
  logic            terr_q;
  logic [IW-1:0]   win;
  logic            any;
  logic            abort;
  logic            wd_hit;
  logic            rel;
  logic            tout;

  assign any    = |pend_q;
  assign abort  = |(bus.Req_Clr & grant_q);
  assign wd_hit = (wdog == TW'(TIMEOUT_CYC - 1));
  assign rel    = (state == GRANT)
                & (bus.Done | abort | wd_hit);
  // Done or abort on the timeout cycle is a clean release
  assign tout     = rel & ~bus.Done & ~abort;
  assign rel_mask = rel ? grant_q : '0;

  // Clear beats release beats set
  assign pend_d = (pend_q | bus.Req_Set)
                & ~bus.Req_Clr
                & ~rel_mask;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pend_q[IW'(k)]) win = IW'(k);
    end
  end
`else
  logic [IW-1:0] last;

  // Scan downward so the index nearest last+1 wins
  always_comb begin
    int j;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(last) + 1 + k;
      if (j >= NREQ) j = j - NREQ;
      if (pend_q[IW'(j)]) win = IW'(j);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      last <= IW'(NREQ - 1);
    end else if (state == IDLE && any) begin
      last <= win;
    end
  end
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (any) state_d = GRANT;
      GRANT:   if (rel) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pend_q  <= '0;
      grant_q <= '0;
      wdog    <= '0;
      terr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      terr_q <= tout;
      unique case (state)
        IDLE: begin
          wdog <= '0;
          if (any) grant_q <= NREQ'(1) << win;
        end
        GRANT: begin
          wdog <= wdog + 1'b1;
          if (rel) grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Grant       = grant_q;
    bus.Pending     = pend_q;
    bus.Timeout_Err = terr_q;
    bus.Busy        = (state != IDLE);
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboarded random/directed bench for mult_share_arbiter.
module tb_mult_share_arbiter;
  localparam int N   = 2;
  localparam int TMO = 4;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         busy;
    logic [N-1:0] pend;
    logic         terr;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sbq[$];

  // Reference: who owns the MAC, for how long, and whether
  // we are in the post-release bubble.
  logic [N-1:0] m_pend;
  int           m_owner;
  int           m_age;
  int           m_next;
  bit           m_bubble;

  mult_share_arbiter_if #(.NREQ(N)) bus ();

  mult_share_arbiter #(
    .NREQ(N),
    .TIMEOUT_CYC(TMO),
    .TW(8)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic m_reset();
    m_pend   = '0;
    m_owner  = -1;
    m_age    = 0;
    m_next   = 0;
    m_bubble = 0;
  endtask

  task automatic push_exp(input bit to);
    exp_t e;
    e.grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.busy  = (m_owner >= 0) || m_bubble;
    e.pend  = m_pend;
    e.terr  = to;
    sbq.push_back(e);
  endtask

  task automatic model(input logic [N-1:0] s,
                       input logic [N-1:0] c,
                       input logic d);
    bit rel = 0;
    bit to  = 0;
    int w   = -1;
    logic [N-1:0] np;
    if (m_owner >= 0) begin
      m_age++;
      if (d || c[m_owner]) rel = 1;
      else if (m_age == TMO) begin
        rel = 1;
        to  = 1;
      end
    end else if (!m_bubble) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_next + k) % N;
        if (w < 0 && m_pend[i]) w = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (c[i])                    np[i] = 1'b0;
      else if (rel && i == m_owner) np[i] = 1'b0;
      else if (s[i])               np[i] = 1'b1;
      else                         np[i] = m_pend[i];
    end
    m_pend = np;
    if (rel) begin
      m_owner  = -1;
      m_bubble = 1;
    end else if (m_bubble) begin
      m_bubble = 0;
    end else if (w >= 0) begin
      m_owner = w;
      m_age   = 0;
`ifdef ARB_FIXED_PRIO_EN
      m_next  = 0;
`else
      m_next  = (w + 1) % N;
`endif
    end
    push_exp(to);
  endtask

  // Called on a negedge; returns on the following negedge.
  task automatic step(input logic [N-1:0] s,
                      input logic [N-1:0] c,
                      input logic d);
    bus.Req_Set = s;
    bus.Req_Clr = c;
    bus.Done    = d;
    @(posedge Clk);
    model(s, c, d);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    bus.Req_Set = '0;
    bus.Req_Clr = '0;
    bus.Done    = 1'b0;
    #2 Rst = 1'b1;
    #1;
    chk("rst_grant", int'(bus.Grant), 0);
    chk("rst_busy", int'(bus.Busy), 0);
    chk("rst_pend", int'(bus.Pending), 0);
    chk("rst_terr", int'(bus.Timeout_Err), 0);
    m_reset();
    @(posedge Clk);
    push_exp(1'b0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("grant", int'(bus.Grant), int'(e.grant));
      chk("busy", int'(bus.Busy), int'(e.busy));
      chk("pending", int'(bus.Pending), int'(e.pend));
      chk("timeout_err", int'(bus.Timeout_Err), int'(e.terr));
    end
  end

  initial begin
    Rst         = 1'b1;
    bus.Req_Set = '0;
    bus.Req_Clr = '0;
    bus.Done    = 1'b0;
    m_reset();
    repeat (2) @(negedge Clk);
    chk("init_grant", int'(bus.Grant), 0);
    chk("init_busy", int'(bus.Busy), 0);
    chk("init_pend", int'(bus.Pending), 0);
    chk("init_terr", int'(bus.Timeout_Err), 0);
    Rst = 1'b0;

    // reset in the middle of a grant, then restart
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    do_reset();
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    repeat (2) step(2'b00, 2'b00, 1'b0);

    // both pending, Done on the third grant cycle
    step(2'b11, 2'b00, 1'b0);
    repeat (3) begin
      step(2'b00, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b1);
      step(2'b01, 2'b00, 1'b0);
    end
    repeat (6) step(2'b00, 2'b00, 1'b1);

    // simultaneous set and clear
    step(2'b10, 2'b10, 1'b0);
    repeat (2) step(2'b00, 2'b00, 1'b0);

    // abort of the granted requester
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    repeat (2) step(2'b00, 2'b00, 1'b0);

    // watchdog expiry, then Done on the last allowed cycle
    step(2'b01, 2'b00, 1'b0);
    repeat (7) step(2'b00, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    repeat (4) step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    repeat (2) step(2'b00, 2'b00, 1'b0);

    // Done while idle
    repeat (3) step(2'b00, 2'b00, 1'b1);

    for (int n = 0; n < 1500; n++) begin
      logic [N-1:0] s;
      logic [N-1:0] c;
      logic         d;
      s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      c = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      d = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(s, c, d);
    end

    repeat (2) step(2'b00, 2'b00, 1'b0);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
